// File: rtl/lp_calc_pkg.sv
// rtl/lp_calc_pkg.sv - shared op encodings and FSM state type for the sequential calculator
//
// Purpose: operation codes carried on op_i and the handshake FSM state type,
// imported by lp_calc_arith_seq and lp_calc_div_iter.
package lp_calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lp_calc_div_iter.sv
// rtl/lp_calc_div_iter.sv - iterative restoring divider, one quotient bit per cycle
//
// Purpose: unsigned WIDTH-bit restoring division. The start cycle loads the
// operands and performs the first iteration, so the quotient is final after
// WIDTH edges and done_o pulses for one cycle right after that.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   start_i              launch a division (divisor must be non-zero)
//   dividend_i/divisor_i operands, sampled only while start_i is high
//   done_o               one-cycle pulse, quot_o valid from this cycle on
//   quot_o               quotient, held until the next start
module lp_calc_div_iter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o
);
  import lp_calc_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dsr_q, dsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rem_src, quot_src, dsr_src;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;

  always_comb begin
    // On start the step works straight from the operand inputs.
    rem_src  = start_i ? '0 : rem_q;
    quot_src = start_i ? dividend_i : quot_q;
    dsr_src  = start_i ? divisor_i : dsr_q;
    shifted  = {rem_src, quot_src[WIDTH-1]};
    diff     = shifted - {1'b0, dsr_src};
    // Partial remainder stays below the divisor, so the borrow bit alone
    // tells whether the trial subtraction fits.
    ge       = !diff[WIDTH];

    rem_d  = rem_q;
    quot_d = quot_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start_i || (cnt_q != '0)) begin
      rem_d  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quot_d = {quot_src[WIDTH-2:0], ge};
      dsr_d  = dsr_src;
      cnt_d  = start_i ? CNT_INIT : (cnt_q - CNT_ONE);
      done_d = !start_i && (cnt_q == CNT_ONE);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quot_q <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign quot_o = quot_q;

endmodule

// File: rtl/lp_calc_arith_seq.sv
// rtl/lp_calc_arith_seq.sv - sequential add/sub/mul/div calculator behind valid/ready handshakes
//
// Purpose: add, sub and mul finish in one cycle; div iterates WIDTH cycles in
// lp_calc_div_iter. Divide by zero returns result 0 with dbz_o set, latency 1.
// Optional build macro: LP_CALC_REUSE_EN keeps a tag (a, b, quotient) of the
// last completed division and answers a repeated division in one cycle.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   in_valid_i/in_ready_o   request handshake
//   a_i, b_i, op_i          unsigned operands and op code (00 add, 01 sub, 10 mul, 11 div)
//   out_valid_o/out_ready_i result handshake
//   result_o, dbz_o         2*WIDTH-bit result and divide-by-zero flag
module lp_calc_arith_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [1:0]         op_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               dbz_o
);
  import lp_calc_pkg::*;

  state_e             state_q, state_d, launch_state;
  logic [2*WIDTH-1:0] result_q, result_d, launch_result;
  logic               dbz_q, dbz_d, launch_dbz;
  logic [2*WIDTH-1:0] a_ext, b_ext;
  logic               accept, is_div, div_start, div_done, tag_hit;
  logic [WIDTH-1:0]   div_quot, hit_quot;

  assign a_ext = {{WIDTH{1'b0}}, a_i};
  assign b_ext = {{WIDTH{1'b0}}, b_i};

  // Reset forces the FSM to IDLE, so rst_i gates in_ready_o explicitly.
  assign in_ready_o = !rst_i && ((state_q == IDLE) || ((state_q == DONE) && out_ready_i));
  assign accept     = in_valid_i && in_ready_o;
  assign is_div     = (op_e'(op_i) == OP_DIV);
  assign div_start  = accept && is_div && (b_i != '0) && !tag_hit;

`ifdef LP_CALC_REUSE_EN
  logic             tag_valid_q;
  logic [WIDTH-1:0] tag_a_q, tag_b_q, tag_quot_q, req_a_q, req_b_q;

  assign tag_hit  = tag_valid_q && (tag_a_q == a_i) && (tag_b_q == b_i);
  assign hit_quot = tag_quot_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_valid_q <= 1'b0;
      tag_a_q     <= '0;
      tag_b_q     <= '0;
      tag_quot_q  <= '0;
      req_a_q     <= '0;
      req_b_q     <= '0;
    end else begin
      if (div_start) begin
        req_a_q <= a_i;
        req_b_q <= b_i;
      end
      // Only iterated divisions refresh the tag; dbz requests never reach DIV.
      if ((state_q == DIV) && div_done) begin
        tag_valid_q <= 1'b1;
        tag_a_q     <= req_a_q;
        tag_b_q     <= req_b_q;
        tag_quot_q  <= div_quot;
      end
    end
  end
`else
  assign tag_hit  = 1'b0;
  assign hit_quot = '0;
`endif

  lp_calc_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (div_start),
    .dividend_i (a_i),
    .divisor_i  (b_i),
    .done_o     (div_done),
    .quot_o     (div_quot)
  );

  // Outcome of accepting the request currently on the inputs.
  always_comb begin
    launch_state  = DONE;
    launch_result = '0;
    launch_dbz    = 1'b0;
    case (op_e'(op_i))
      OP_ADD: launch_result = a_ext + b_ext;
      OP_SUB: launch_result = a_ext - b_ext;
      OP_MUL: launch_result = a_ext * b_ext;
      OP_DIV: begin
        if (b_i == '0)   launch_dbz    = 1'b1;
        else if (tag_hit) launch_result = {{WIDTH{1'b0}}, hit_quot};
        else              launch_state  = DIV;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = launch_state;
          result_d = launch_result;
          dbz_d    = launch_dbz;
        end
      end
      DIV: begin
        if (div_done) begin
          state_d  = DONE;
          result_d = {{WIDTH{1'b0}}, div_quot};
          dbz_d    = 1'b0;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
        // Accept in DONE implies out_ready_i: retire and relaunch on one edge.
        if (accept) begin
          state_d  = launch_state;
          result_d = launch_result;
          dbz_d    = launch_dbz;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign out_valid_o = (state_q == DONE);
  assign result_o    = result_q;
  assign dbz_o       = dbz_q;

endmodule

// File: tb/tb_lp_calc_arith_seq.sv
// tb/tb_lp_calc_arith_seq.sv - directed table-driven bench for lp_calc_arith_seq (WIDTH 4 and 8)
module tb_lp_calc_arith_seq;

  localparam int REUSE_LAT =
`ifdef LP_CALC_REUSE_EN
    1;
`else
    5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       in_valid4, in_ready4, out_valid4, out_ready4, dbz4;
  logic [3:0] a4, b4;
  logic [1:0] op4;
  logic [7:0] result4;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, dbz8;
  logic [7:0]  a8, b8;
  logic [1:0]  op8;
  logic [15:0] result8;

  lp_calc_arith_seq #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .a_i(a4), .b_i(b4), .op_i(op4), .out_valid_o(out_valid4),
    .out_ready_i(out_ready4), .result_o(result4), .dbz_o(dbz4)
  );

  lp_calc_arith_seq #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid8), .in_ready_o(in_ready8),
    .a_i(a8), .b_i(b8), .op_i(op8), .out_valid_o(out_valid8),
    .out_ready_i(out_ready8), .result_o(result8), .dbz_o(dbz8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  // Issue one request on dut4 and wait (bounded) for its result.
  task automatic do4(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                     output logic [7:0] res, output logic dbz, output int lat,
                     output int nbusy, output logic rdy);
    op4 = op; a4 = a; b4 = b; in_valid4 = 1'b1;
    rdy = in_ready4;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 1;
    nbusy = 0;
    while (!out_valid4 && lat < 40) begin
      if (!in_ready4) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    res = result4;
    dbz = dbz4;
  endtask

  logic [7:0] r;
  logic       d, rdy;
  int         lat, nbusy, cnt;

  initial begin
    vecs[0]  = '{2'd0, 4'd15, 4'd15, 8'h1E, 1'b0, 1};
    vecs[1]  = '{2'd1, 4'd3,  4'd5,  8'hFE, 1'b0, 1};
    vecs[2]  = '{2'd2, 4'd15, 4'd15, 8'hE1, 1'b0, 1};
    vecs[3]  = '{2'd0, 4'd0,  4'd0,  8'h00, 1'b0, 1};
    vecs[4]  = '{2'd1, 4'd0,  4'd1,  8'hFF, 1'b0, 1};
    vecs[5]  = '{2'd2, 4'd7,  4'd9,  8'h3F, 1'b0, 1};
    vecs[6]  = '{2'd3, 4'd13, 4'd3,  8'h04, 1'b0, 5};
    vecs[7]  = '{2'd3, 4'd9,  4'd0,  8'h00, 1'b1, 1};
    vecs[8]  = '{2'd3, 4'd15, 4'd1,  8'h0F, 1'b0, 5};
    vecs[9]  = '{2'd3, 4'd0,  4'd5,  8'h00, 1'b0, 5};
    vecs[10] = '{2'd3, 4'd7,  4'd15, 8'h00, 1'b0, 5};
    vecs[11] = '{2'd1, 4'd5,  4'd3,  8'h02, 1'b0, 1};

    rst = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; op4 = '0; out_ready4 = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready4, 0);
    chk("reset_out_valid", out_valid4, 0);
    chk("reset_result", result4, 0);
    chk("reset_dbz", dbz4, 0);
    rst = 1'b0;
    #1;
    chk("release_in_ready", in_ready4, 1);
    @(posedge clk); #1;

    // Table of single requests, each retired before the next.
    for (int i = 0; i < 12; i++) begin
      do4(vecs[i].op, vecs[i].a, vecs[i].b, r, d, lat, nbusy, rdy);
      chk($sformatf("vec%0d_ready", i), rdy, 1);
      chk($sformatf("vec%0d_result", i), r, vecs[i].res);
      chk($sformatf("vec%0d_dbz", i), d, vecs[i].dbz);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), nbusy, vecs[i].lat - 1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_retired", i), out_valid4, 0);
    end

    // Back-to-back single-cycle ops with out_ready held high.
    in_valid4 = 1'b1; op4 = 2'd0; a4 = 4'd15; b4 = 4'd15;
    @(posedge clk); #1;
    chk("b2b_add_valid", out_valid4, 1);
    chk("b2b_add_result", result4, 8'h1E);
    chk("b2b_add_ready", in_ready4, 1);
    op4 = 2'd1; a4 = 4'd3; b4 = 4'd5;
    @(posedge clk); #1;
    chk("b2b_sub_valid", out_valid4, 1);
    chk("b2b_sub_result", result4, 8'hFE);
    chk("b2b_sub_ready", in_ready4, 1);
    op4 = 2'd2; a4 = 4'd15; b4 = 4'd15;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    chk("b2b_mul_valid", out_valid4, 1);
    chk("b2b_mul_result", result4, 8'hE1);
    @(posedge clk); #1;
    chk("b2b_drain", out_valid4, 0);

    // Reset while a result is pending: outputs clear at once.
    out_ready4 = 1'b0;
    in_valid4 = 1'b1; op4 = 2'd0; a4 = 4'd15; b4 = 4'd15;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    chk("pend_valid", out_valid4, 1);
    chk("pend_result", result4, 8'h1E);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid4, 0);
    chk("async_rst_result", result4, 0);
    chk("async_rst_dbz", dbz4, 0);
    chk("async_rst_ready", in_ready4, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rerelease_ready", in_ready4, 1);

    // Reset in the middle of a division aborts it.
    out_ready4 = 1'b1;
    in_valid4 = 1'b1; op4 = 2'd3; a4 = 4'd13; b4 = 4'd3;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid4) cnt++;
    end
    chk("abort_no_valid", cnt, 0);

    // Repeated divisions: tag (if built) was cleared by the reset above.
    do4(2'd3, 4'd13, 4'd3, r, d, lat, nbusy, rdy);
    chk("rep1_result", r, 8'h04);
    chk("rep1_latency", lat, 5);
    @(posedge clk); #1;
    do4(2'd3, 4'd13, 4'd3, r, d, lat, nbusy, rdy);
    chk("rep2_result", r, 8'h04);
    chk("rep2_latency", lat, REUSE_LAT);
    @(posedge clk); #1;
    do4(2'd3, 4'd13, 4'd2, r, d, lat, nbusy, rdy);
    chk("rep3_result", r, 8'h06);
    chk("rep3_latency", lat, 5);
    @(posedge clk); #1;
    do4(2'd3, 4'd9, 4'd0, r, d, lat, nbusy, rdy);
    chk("dbz_mid_dbz", d, 1);
    chk("dbz_mid_result", r, 8'h00);
    @(posedge clk); #1;
    do4(2'd3, 4'd13, 4'd2, r, d, lat, nbusy, rdy);
    chk("rep4_result", r, 8'h06);
    chk("rep4_dbz", d, 0);
    chk("rep4_latency", lat, REUSE_LAT);
    @(posedge clk); #1;

    // WIDTH=8: 200/7 with backpressure, a new request waiting meanwhile.
    out_ready8 = 1'b0;
    in_valid8 = 1'b1; op8 = 2'd3; a8 = 8'd200; b8 = 8'd7;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w8_div_latency", lat, 9);
    in_valid8 = 1'b1; op8 = 2'd0; a8 = 8'd1; b8 = 8'd2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w8_hold%0d_valid", k), out_valid8, 1);
      chk($sformatf("w8_hold%0d_result", k), result8, 16'd28);
      chk($sformatf("w8_hold%0d_dbz", k), dbz8, 0);
      chk($sformatf("w8_hold%0d_ready", k), in_ready8, 0);
      @(posedge clk); #1;
    end
    out_ready8 = 1'b1;
    #1;
    chk("w8_ready_on_retire", in_ready8, 1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk("w8_next_valid", out_valid8, 1);
    chk("w8_next_result", result8, 16'd3);
    @(posedge clk); #1;
    chk("w8_drain", out_valid8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
